// File: rtl/mem_arbiter.sv
// Round-robin arbiter that gives NCORES cores access to one shared single-port memory.
// Only one transfer is in flight at a time; a transfer that is never acknowledged ends in a timeout.
module mem_arbiter #(
  parameter int NCORES  = 4,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk_test,
  input  logic                 reset,
  input  logic [NCORES-1:0]    core_req,
  input  logic [NCORES-1:0]    core_we,
  input  logic [NCORES*AW-1:0] core_addr,
  input  logic [NCORES*DW-1:0] core_wdata,
  output logic [NCORES-1:0]    core_gnt,
  output logic [NCORES-1:0]    core_done,
  output logic                 core_err,
  output logic [DW-1:0]        core_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  input  logic                 mem_ready,
  output logic [1:0]           o_dbg_state
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_win;
  logic [PW-1:0]     w_pick;
  logic [PW-1:0]     w_idx;
  logic [NCORES-1:0] w_pick_oh;
  logic              w_any;
  logic              w_timeout;
  logic [CW-1:0]     r_cnt;
  logic [NCORES-1:0] r_gnt;
  logic [NCORES-1:0] r_done;
  logic              r_err;
  logic [DW-1:0]     r_rdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [AW-1:0]     r_mem_addr;
  logic [DW-1:0]     r_mem_wdata;

  // Scan upward from the round-robin pointer; the first requester found wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int i = 0; i < NCORES; i++) begin
      w_idx = PW'((int'(r_ptr) + i) % NCORES);
      if (!w_any && core_req[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  assign w_pick_oh = {{(NCORES-1){1'b0}}, 1'b1} << w_pick;
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_ACCESS;
      S_ACCESS: if (mem_ready || w_timeout) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_test) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Memory handshake: mem_en and the address/data/we bundle are held stable from the
  // first ACCESS cycle until the edge that samples mem_ready = 1 (or the timeout edge);
  // mem_rdata is only taken at that edge and only for reads.
  always_ff @(posedge clk_test) begin
    if (!reset) begin
      r_ptr       <= '0;
      r_win       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win       <= w_pick;
            r_gnt       <= w_pick_oh;
            r_mem_en    <= 1'b1;
            r_mem_we    <= core_we[w_pick];
            r_mem_addr  <= core_addr[int'(w_pick)*AW +: AW];
            r_mem_wdata <= core_wdata[int'(w_pick)*DW +: DW];
            r_cnt       <= '0;
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            r_mem_en <= 1'b0;
            r_done   <= r_gnt;
            r_err    <= 1'b0;
            if (!r_mem_we) r_rdata <= mem_rdata;
          end else if (w_timeout) begin
            r_mem_en <= 1'b0;
            r_done   <= r_gnt;
            r_err    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_gnt  <= '0;
          r_done <= '0;
          r_ptr  <= PW'((int'(r_win) + 1) % NCORES);
        end
        default: begin
          r_gnt  <= '0;
          r_done <= '0;
        end
      endcase
    end
  end

  assign core_gnt    = r_gnt;
  assign core_done   = r_done;
  assign core_err    = r_err;
  assign core_rdata  = r_rdata;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction driver plus memory responder, a reference model of the
// round-robin rules, and a monitor that checks every memory access and completion against it.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 15;
  localparam int EW = 8 + 1 + 1 + AW + DW + DW + 8;

  // ---------------- clock / reset ----------------
  logic clk_test = 1'b0;
  logic reset    = 1'b0;
  always #5 clk_test = ~clk_test;

  logic [N-1:0]    core_req   = '0;
  logic [N-1:0]    core_we    = '0;
  logic [N*AW-1:0] core_addr  = '0;
  logic [N*DW-1:0] core_wdata = '0;
  logic [N-1:0]    core_gnt;
  logic [N-1:0]    core_done;
  logic            core_err;
  logic [DW-1:0]   core_rdata;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata  = '0;
  logic            mem_ready  = 1'b0;
  logic [1:0]      dbg_state;

  mem_arbiter #(.NCORES(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_test   (clk_test),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_done  (core_done),
    .core_err   (core_err),
    .core_rdata (core_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            done_cyc_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;

  // Reference model: round-robin pointer and the last read value seen by the cores.
  int            m_ptr   = 0;
  logic [DW-1:0] m_rdata = '0;

  // Staged stimulus for the next transaction.
  logic [N-1:0]  st_we;
  logic [AW-1:0] st_addr[N];
  logic [DW-1:0] st_wdata[N];
  logic [DW-1:0] st_mrd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event missing expected event present (t=%0t)", name, $time);
  endtask

  function automatic logic [EW-1:0] pack_exp(input int win, input logic err, input logic we,
                                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                             input logic [DW-1:0] rdata, input int ncyc);
    return {8'(win), err, we, addr, wdata, rdata, 8'(ncyc)};
  endfunction

  function automatic int            f_win  (input logic [EW-1:0] e); return int'(e[EW-1 -: 8]); endfunction
  function automatic logic          f_err  (input logic [EW-1:0] e); return e[EW-9];            endfunction
  function automatic logic          f_we   (input logic [EW-1:0] e); return e[EW-10];           endfunction
  function automatic logic [AW-1:0] f_addr (input logic [EW-1:0] e); return e[EW-11 -: AW];     endfunction
  function automatic logic [DW-1:0] f_wdata(input logic [EW-1:0] e); return e[8+DW +: DW];      endfunction
  function automatic logic [DW-1:0] f_rdata(input logic [EW-1:0] e); return e[8 +: DW];         endfunction
  function automatic int            f_ncyc (input logic [EW-1:0] e); return int'(e[7:0]);       endfunction

  function automatic int model_pick(input logic [N-1:0] req);
    for (int i = 0; i < N; i++)
      if (req[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [EW-1:0] e;
    int acc_cnt;
    acc_cnt = 0;
    forever begin
      @(negedge clk_test);
      cyc++;
      check("gnt_onehot0", 64'($onehot0(core_gnt)), 64'd1);
      check("done_onehot0", 64'($onehot0(core_done)), 64'd1);
      if (mem_en) begin
        acc_cnt++;
        if (exp_q.size() == 0) fail_now("unexpected_mem_en");
        else begin
          e = exp_q[0];
          check("mem_addr", 64'(mem_addr), 64'(f_addr(e)));
          check("mem_we", 64'(mem_we), 64'(f_we(e)));
          check("mem_wdata", 64'(mem_wdata), 64'(f_wdata(e)));
          check("gnt_access", 64'(core_gnt), 64'(1) << f_win(e));
          check("done_in_access", 64'(core_done), 64'd0);
        end
      end else if (core_done != '0) begin
        if (exp_q.size() == 0) fail_now("unexpected_core_done");
        else begin
          e = exp_q.pop_front();
          check("done_core", 64'(core_done), 64'(1) << f_win(e));
          check("gnt_done", 64'(core_gnt), 64'(1) << f_win(e));
          check("core_err", 64'(core_err), 64'(f_err(e)));
          check("core_rdata", 64'(core_rdata), 64'(f_rdata(e)));
          check("access_cycles", 64'(acc_cnt), 64'(f_ncyc(e)));
          done_cyc_q.push_back(cyc);
        end
        acc_cnt = 0;
      end else begin
        acc_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic randomize_stage();
    st_we  = N'($urandom);
    st_mrd = DW'($urandom);
    for (int i = 0; i < N; i++) begin
      st_addr[i]  = AW'($urandom);
      st_wdata[i] = DW'($urandom);
    end
  endtask

  task automatic idle(input int n);
    core_req  = '0;
    mem_ready = 1'b0;
    repeat (n) @(negedge clk_test);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   64'(core_gnt),   64'd0);
    check({tag, "_done"},  64'(core_done),  64'd0);
    check({tag, "_err"},   64'(core_err),   64'd0);
    check({tag, "_rdata"}, 64'(core_rdata), 64'd0);
    check({tag, "_mem_en"}, 64'(mem_en),    64'd0);
    check({tag, "_mem_we"}, 64'(mem_we),    64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  // One transaction: drive staged inputs, act as the memory (ready after lat ACCESS cycles,
  // never if lat >= TO), scramble core inputs during the access. Returns at the DONE cycle.
  task automatic run_txn(input logic [N-1:0] req, input int lat, input bit drop, input bit abort);
    int win, k, ncyc;
    logic err;
    logic [DW-1:0] rd_exp;
    core_req  = req;
    core_we   = st_we;
    mem_rdata = st_mrd;
    mem_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      core_addr[i*AW +: AW]  = st_addr[i];
      core_wdata[i*DW +: DW] = st_wdata[i];
    end
    win    = model_pick(req);
    err    = (lat >= TO);
    ncyc   = err ? TO : lat + 1;
    rd_exp = (!st_we[win] && !err) ? st_mrd : m_rdata;
    exp_q.push_back(pack_exp(win, err, st_we[win], st_addr[win], st_wdata[win], rd_exp, ncyc));

    k = 0;
    while (!mem_en && k < 4) begin
      @(negedge clk_test);
      k++;
    end
    if (!mem_en) begin
      fail_now("grant_wait");
      void'(exp_q.pop_back());
      return;
    end

    k = 0;
    forever begin
      mem_ready = (k == lat);
      core_req  = N'($urandom);
      core_req[win] = !drop;
      core_we   = N'($urandom);
      for (int i = 0; i < N; i++) begin
        core_addr[i*AW +: AW]  = AW'($urandom);
        core_wdata[i*DW +: DW] = DW'($urandom);
      end
      if (abort && k == 1) begin
        reset     = 1'b0;
        core_req  = '0;
        mem_ready = 1'b0;
        @(negedge clk_test);
        check_all_zero("abort");
        reset = 1'b1;
        void'(exp_q.pop_back());
        m_ptr   = 0;
        m_rdata = '0;
        return;
      end
      @(negedge clk_test);
      k++;
      if (!mem_en) break;
      if (k > TO + 4) begin
        fail_now("access_stuck");
        break;
      end
    end
    mem_ready = 1'b0;
    m_ptr     = (win + 1) % N;
    m_rdata   = rd_exp;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int lat;
    reset = 1'b0;
    repeat (3) @(negedge clk_test);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk_test);

    // Single read by core 2 with one wait cycle.
    randomize_stage();
    st_we[2] = 1'b0; st_addr[2] = 16'h0010; st_mrd = 16'hBEEF;
    run_txn(4'b0100, 1, 1'b0, 1'b0);
    // Pointer now at 3: all requesting, core 3 must win.
    randomize_stage();
    run_txn(4'b1111, 0, 1'b0, 1'b0);
    idle(2);

    // Continuous requests from every core, zero wait: order 0,1,2,3,0, three cycles apart.
    done_cyc_q.delete();
    for (int i = 0; i < 5; i++) begin
      randomize_stage();
      run_txn(4'b1111, 0, 1'b0, 1'b0);
    end
    idle(2);
    check("burst_count", 64'(done_cyc_q.size()), 64'd5);
    for (int i = 1; i < done_cyc_q.size(); i++)
      check("burst_spacing", 64'(done_cyc_q[i] - done_cyc_q[i-1]), 64'd3);

    // Write from core 1 with three wait cycles.
    randomize_stage();
    st_we[1] = 1'b1; st_addr[1] = 16'h0020; st_wdata[1] = 16'h1234;
    run_txn(4'b0010, 3, 1'b0, 1'b0);
    idle(1);

    // Memory never answers: timeout after 15 ACCESS cycles.
    randomize_stage();
    st_we[0] = 1'b0;
    run_txn(4'b0001, 100, 1'b0, 1'b0);
    idle(2);

    // Reset during the second ACCESS cycle, then arbitration restarts at core 0.
    randomize_stage();
    run_txn(4'b0100, 100, 1'b0, 1'b1);
    idle(2);
    randomize_stage();
    run_txn(4'b1111, 2, 1'b0, 1'b0);
    idle(1);

    // Core 3 drops its request mid-access; the transfer still completes.
    randomize_stage();
    run_txn(4'b1000, 2, 1'b1, 1'b0);
    idle(1);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      randomize_stage();
      lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 17)) : int'($urandom_range(0, 3));
      run_txn(N'($urandom_range(1, (1 << N) - 1)), lat, 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(3);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: NCORES, 4, number of requesting cores.
REQ-002 Parameter: AW, 16, address width.
REQ-003 Parameter: DW, 16, data width.
REQ-004 Parameter: TIMEOUT, 15, maximum ACCESS cycles waiting for mem_ready.
REQ-005 Port: clk_test  input  1  clock; all state changes on its rising edge.
REQ-006 Port: reset  input  1  reset, synchronous, active-low.
REQ-007 Port: core_req  input  NCORES  per-core access request, level.
REQ-008 Port: core_we  input  NCORES  per-core write enable (1 = write, 0 = read).
REQ-009 Port: core_addr  input  NCORES*AW  flattened addresses; core i in bits [i*AW +: AW].
REQ-010 Port: core_wdata  input  NCORES*DW  flattened write data, same packing.
REQ-011 Port: core_gnt  output  NCORES  one-hot grant, registered.
REQ-012 Port: core_done  output  NCORES  one-cycle completion pulse for the granted core.
REQ-013 Port: core_err  output  1  timeout flag; valid only while core_done is nonzero.
REQ-014 Port: core_rdata  output  DW  read data; holds the last captured value.
REQ-015 Port: mem_en  output  1  memory access strobe.
REQ-016 Port: mem_we  output  1  memory write enable.
REQ-017 Port: mem_addr  output  AW  memory address.
REQ-018 Port: mem_wdata  output  DW  memory write data.
REQ-019 Port: mem_rdata  input  DW  memory read data; valid when mem_ready = 1.
REQ-020 Port: mem_ready  input  1  memory completion; sampled only in ACCESS.

Function
REQ-021 FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-022 In IDLE with any core_req bit set, the winner SHALL be the first requester found scanning upward (modulo NCORES) from round-robin pointer ptr; at the next edge the FSM enters ACCESS.
REQ-023 On the IDLE->ACCESS edge: core_gnt[winner] set; mem_addr, mem_we, mem_wdata latched from the winner's inputs; mem_en = 1; timeout counter cleared.
REQ-024 In ACCESS, mem_en, mem_addr, mem_we, mem_wdata and core_gnt SHALL hold constant; core_req and core_addr/core_wdata changes are ignored until the next IDLE.
REQ-025 In ACCESS, with mem_ready = 1 at an edge: FSM -> DONE; mem_en cleared; core_rdata <= mem_rdata if mem_we = 0, otherwise unchanged; core_err <= 0.
REQ-026 In ACCESS, with mem_ready = 0 at an edge: counter increments; the edge at which counter equals TIMEOUT-1 SHALL move the FSM to DONE with core_err <= 1 and mem_en cleared, and core_rdata unchanged.
REQ-027 In DONE, core_done[winner] = 1 for exactly one cycle; at the next edge core_gnt and core_done clear, ptr <= (winner+1) mod NCORES, FSM -> IDLE.
REQ-028 Minimum access SHALL take 3 cycles (IDLE, ACCESS, DONE); mem_ready already high in the first ACCESS cycle completes that cycle.
REQ-029 A requester SHALL hold core_req until its core_done pulse; dropping core_req mid-ACCESS SHALL NOT abort the transfer.
REQ-030 No new grant SHALL issue in DONE; a core still requesting after its done competes again from IDLE at the lowest priority.
REQ-031 At most one core_gnt bit and one core_done bit SHALL ever be set.

Reset
REQ-032 With reset = 0 at a rising edge: FSM = IDLE, ptr = 0, counter = 0; core_gnt, core_done, core_err, core_rdata, mem_en, mem_we, mem_addr and mem_wdata all 0.
REQ-033 Reset asserted mid-ACCESS SHALL abandon the transfer without any core_done pulse; mem_en is 0 at the first edge with reset = 0.

Verification
REQ-034 Reset, then core_req = 4'b0100, core_we[2] = 0, addr2 = 16'h0010, mem_ready high one cycle after mem_en, mem_rdata = 16'hBEEF -> core_gnt = 4'b0100; core_done[2] pulses once; core_rdata = 16'hBEEF; ptr = 3.
REQ-035 core_req = 4'b1111 held continuously, mem_ready = 1 immediately -> grant order 0,1,2,3,0; each access 3 cycles.
REQ-036 Write from core 1: addr = 16'h0020, wdata = 16'h1234, mem_ready delayed 3 cycles -> mem_we = 1; mem_addr = 16'h0020 and mem_wdata = 16'h1234 stable all 4 ACCESS cycles; core_rdata unchanged.
REQ-037 mem_ready held 0 -> exactly 15 ACCESS cycles, then DONE with core_err = 1 and core_done pulse; FSM returns to IDLE.
REQ-038 reset = 0 during the 2nd ACCESS cycle -> all outputs 0 at the next edge; no core_done pulse; next grant starts from core 0.
REQ-039 core_req[3] dropped during ACCESS for core 3 -> transfer completes; core_done[3] still pulses once.
